i2c_target_regs: RTL

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs_pkg.sv | 41 ++++
 rtl/i2c_target_regs_if.sv | 20 ++
 rtl/i2c_bus_monitor.sv | 46 ++++
 rtl/i2c_target_regs.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C register target: device address, register map
// sizing, FSM state encoding and the debug view of the FSM.
package i2c_target_regs_pkg;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h50;
  localparam int         NUM_REGS         = 8;
  localparam int         RO_REGS          = 4;
  localparam int         PTR_W            = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [PTR_W-1:0] ptr;
  } dbg_t;

  // Registers below RO_REGS mirror status; the rest are the writable control bytes.
  function automatic logic is_writable(input logic [PTR_W-1:0] p);
    return int'(p) >= RO_REGS;
  endfunction

  function automatic logic [7:0] reg_byte(input logic [PTR_W-1:0] p,
                                          input logic [31:0] status,
                                          input logic [31:0] ctrl);
    logic [63:0] all_regs;
    all_regs = {ctrl, status};
    return all_regs[{p, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/i2c_target_regs_if.sv
// Link between the pin-side bus monitor and the target FSM: raw pins in,
// synchronized SDA plus SCL edge and START/STOP events out.
interface i2c_target_regs_if;
  logic scl_raw;
  logic sda_raw;
  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  modport master (
    input  scl_raw, sda_raw,
    output sda, scl_rise, scl_fall, start_det, stop_det
  );

  modport slave (
    input sda, scl_rise, scl_fall, start_det, stop_det
  );
endinterface

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into the clk domain and derives one-cycle SCL edge and
// START/STOP events from the synchronized levels.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  i2c_target_regs_if.master bus
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_q;
  logic                   sda_q;

  // Flops reset to 1 so an idle (pulled-up) bus produces no spurious events.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync[0] <= bus.scl_raw;
      sda_sync[0] <= bus.sda_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign bus.sda       = sda_s;
  assign bus.scl_rise  = scl_s & ~scl_q;
  assign bus.scl_fall  = ~scl_s & scl_q;
  assign bus.start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign bus.stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing 4 read-only status bytes and 4 read/write control bytes
// behind an auto-incrementing register pointer.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe_out,
  input  logic [31:0]      status_in,
  output logic [31:0]      ctrl_out,
  output logic             wr_strobe_out,
  output logic [PTR_W-1:0] wr_addr_out,
  output logic             busy_out,
  output dbg_t             dbg
);

  i2c_target_regs_if bus ();

  assign bus.scl_raw = scl_in;
  assign bus.sda_raw = sda_in;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_bus_monitor (
    .clk (clk_in),
    .rst (rst_in),
    .bus (bus.master)
  );

  state_t           state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift;
  logic [PTR_W-1:0] ptr;
  logic             rw;
  logic             mack;
  logic [7:0]       rx_byte;
  logic [7:0]       rd_byte;

  assign rx_byte   = {shift[6:0], bus.sda};
  assign rd_byte   = reg_byte(ptr, status_in, ctrl_out);
  assign dbg.state = state;
  assign dbg.ptr   = ptr;

  // SDA is sampled on SCL rise; sda_oe_out only moves on SCL fall, one clk later.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      ptr           <= '0;
      rw            <= 1'b0;
      mack          <= 1'b1;
      ctrl_out      <= '0;
      sda_oe_out    <= 1'b0;
      wr_strobe_out <= 1'b0;
      wr_addr_out   <= '0;
      busy_out      <= 1'b0;
    end else begin
      wr_strobe_out <= 1'b0;
      if (bus.start_det) begin
        state      <= ST_ADDR;
        bit_cnt    <= '0;
        sda_oe_out <= 1'b0;
      end else if (bus.stop_det) begin
        state      <= ST_IDLE;
        bit_cnt    <= '0;
        sda_oe_out <= 1'b0;
        busy_out   <= 1'b0;
      end else begin
        unique case (state)
          ST_ADDR, ST_PTR, ST_WR_DATA: begin
            if (bus.scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (state == ST_WR_DATA && bit_cnt == 4'd7 && is_writable(ptr)) begin
                ctrl_out[{ptr[1:0], 3'b000} +: 8] <= rx_byte;
                wr_strobe_out <= 1'b1;
                wr_addr_out   <= ptr;
              end
            end else if (bus.scl_fall && bit_cnt == 4'd8) begin
              bit_cnt    <= '0;
              sda_oe_out <= 1'b1;
              if (state == ST_ADDR) begin
                if (shift[7:1] == DEV_ADDR) begin
                  state    <= ST_ADDR_ACK;
                  rw       <= shift[0];
                  busy_out <= 1'b1;
                end else begin
                  state      <= ST_IGNORE;
                  sda_oe_out <= 1'b0;
                  busy_out   <= 1'b0;
                end
              end else if (state == ST_PTR) begin
                ptr   <= shift[PTR_W-1:0];
                state <= ST_PTR_ACK;
              end else begin
                ptr   <= ptr + 1'b1;
                state <= ST_WR_ACK;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (bus.scl_fall) begin
              bit_cnt <= '0;
              if (rw) begin
                state      <= ST_RD_DATA;
                shift      <= rd_byte;
                sda_oe_out <= ~rd_byte[7];
                ptr        <= ptr + 1'b1;
              end else begin
                state      <= ST_PTR;
                sda_oe_out <= 1'b0;
              end
            end
          end
          ST_PTR_ACK, ST_WR_ACK: begin
            if (bus.scl_fall) begin
              state      <= ST_WR_DATA;
              bit_cnt    <= '0;
              sda_oe_out <= 1'b0;
            end
          end
          ST_RD_DATA: begin
            if (bus.scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (bus.scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state      <= ST_RD_ACK;
                bit_cnt    <= '0;
                sda_oe_out <= 1'b0;
              end else begin
                shift      <= {shift[6:0], 1'b0};
                sda_oe_out <= ~shift[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (bus.scl_rise) begin
              mack <= bus.sda;
            end else if (bus.scl_fall) begin
              bit_cnt <= '0;
              if (mack) begin
                state      <= ST_IGNORE;
                sda_oe_out <= 1'b0;
              end else begin
                state      <= ST_RD_DATA;
                shift      <= rd_byte;
                sda_oe_out <= ~rd_byte[7];
                ptr        <= ptr + 1'b1;
              end
            end
          end
          default: sda_oe_out <= 1'b0;
        endcase
      end
    end
  end

endmodule
